// File: rtl/scalar_digit_scanner_if.sv
// scalar_digit_scanner_if: load/consume handshake between a scalar producer and the digit scanner
interface scalar_digit_scanner_if #(
    parameter int K_WIDTH = 32,
    parameter int DIGIT_W = 1
);
    localparam int ND = K_WIDTH / DIGIT_W;
    localparam int PW = ND > 1 ? $clog2(ND) : 1;
    logic               load;
    logic [K_WIDTH-1:0] k;
    logic               skip_zeros;
    logic               next;
    logic [DIGIT_W-1:0] digit;
    logic               valid;
    logic [PW-1:0]      pos;
    logic               last;
    logic               busy;
    logic               done;
    modport master (
        output load, k, skip_zeros, next,
        input  digit, valid, pos, last, busy, done
    );
    modport slave (
        input  load, k, skip_zeros, next,
        output digit, valid, pos, last, busy, done
    );
endinterface

// File: rtl/scalar_digit_scanner.sv
// scalar_digit_scanner: presents a registered scalar one digit per consume, optionally skipping leading zeros
module scalar_digit_scanner #(
    parameter int K_WIDTH   = 32,
    parameter int DIGIT_W   = 1,
    parameter bit MSB_FIRST = 1
) (
    input logic clk,
    input logic rst,
    scalar_digit_scanner_if.slave bus
);
    localparam int ND = K_WIDTH / DIGIT_W;
    localparam int PW = ND > 1 ? $clog2(ND) : 1;
    localparam logic [PW-1:0] FIRST_POS = MSB_FIRST ? PW'(ND - 1) : '0;
    localparam logic [PW-1:0] LAST_POS  = MSB_FIRST ? '0 : PW'(ND - 1);
    typedef enum logic [1:0] {IDLE, SKIP, ACTIVE} state_t;
    state_t             state;
    logic [K_WIDTH-1:0] k_reg;
    logic [PW-1:0]      pos;
    logic               done;
    logic [DIGIT_W-1:0] cur;
    logic               at_last;
    logic [PW-1:0]      pos_step;
    always_comb begin
        cur      = k_reg[int'(pos)*DIGIT_W +: DIGIT_W];
        at_last  = pos == LAST_POS;
        pos_step = MSB_FIRST ? pos - PW'(1) : pos + PW'(1);
    end
    // load wins over everything but reset; a load on the final consume suppresses done
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            k_reg <= '0;
            pos   <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (bus.load) begin
                k_reg <= bus.k;
                pos   <= FIRST_POS;
                state <= (bus.skip_zeros && MSB_FIRST) ? SKIP : ACTIVE;
            end else if (state == SKIP) begin
                if (cur == '0 && !at_last) pos <= pos_step;
                else state <= ACTIVE;
            end else if (state == ACTIVE && bus.next) begin
                if (at_last) begin
                    state <= IDLE;
                    done  <= 1'b1;
                end else begin
                    pos <= pos_step;
                end
            end
        end
    end
    assign bus.digit = cur;
    assign bus.valid = state == ACTIVE;
    assign bus.busy  = state != IDLE;
    assign bus.last  = state == ACTIVE && at_last;
    assign bus.pos   = pos;
    assign bus.done  = done;
endmodule
